// File: rtl/instr_fetch_pkg.sv
// Shared widths, address step and default FIFO depth for the fetch stage.
// Optional perf counters are built when IFETCH_PERF_EN is defined.
`ifndef INSTR_FETCH_DEFS
`define INSTR_FETCH_DEFS
`define FULLW 32
`define IADDR_STEP 4
`define IFETCH_DEPTH 2
`endif

package instr_fetch_pkg;
  localparam int FULLW = `FULLW;
  localparam logic [FULLW-1:0] IADDR_STEP = `IADDR_STEP;
  localparam int IFETCH_DEPTH = `IFETCH_DEPTH;

  typedef struct packed {
    logic [FULLW-1:0] pc;
    logic [FULLW-1:0] instr;
  } fetch_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/instr_fetch_ififo.sv
// DEPTH-entry FIFO of {pc, instr}; flush wins over push and pop.
module ififo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = IFETCH_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push_i,
  input  fetch_t        push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_t        head_o,
  output logic [CW-1:0] count_o
);
  fetch_t        mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = inc(wr_q);
      if (pop_i)  rd_d = inc(rd_q);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, one-deep in-flight tracking over a sync-read RAM, redirect flush.
// Define IFETCH_PERF_EN to add saturating perf_fetched / perf_flushed counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          DEPTH     = IFETCH_DEPTH,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              nreset,
  output logic [`FULLW-1:0] imem_addr,
  input  logic [`FULLW-1:0] imem_q,
  input  logic              br_taken,
  input  logic [`FULLW-1:0] br_target,
  input  logic              stall,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
`endif
  output logic [`FULLW-1:0] instr_out,
  output logic [`FULLW-1:0] instr_pc,
  output logic              instr_valid
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FULLW-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic             infl_q, infl_d;
  logic [CW-1:0]    count;
  logic [CW:0]      occ;
  logic             pop, push, issue;
  fetch_t           head;

  assign pop   = instr_valid && !stall && !br_taken;
  assign push  = infl_q && !br_taken;
  // Occupancy after this cycle's pop; counting the in-flight word prevents overflow.
  assign occ   = {1'b0, count} + (CW+1)'(infl_q) - (CW+1)'(instr_valid && !stall);
  assign issue = !br_taken && (occ < (CW+1)'(DEPTH));

  always_comb begin
    pc_d   = pc_q;
    ipc_d  = ipc_q;
    infl_d = 1'b0;
    if (br_taken) begin
      pc_d = br_target & ~32'h3;
    end else if (issue) begin
      pc_d   = pc_q + IADDR_STEP;
      infl_d = 1'b1;
      ipc_d  = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      pc_q   <= RESET_VEC;
      ipc_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ipc_q  <= ipc_d;
      infl_q <= infl_d;
    end
  end

  ififo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .nreset      (nreset),
    .push_i      (push),
    .push_data_i ('{pc: ipc_q, instr: imem_q}),
    .pop_i       (pop),
    .flush_i     (br_taken),
    .head_o      (head),
    .count_o     (count)
  );

  assign imem_addr   = pc_q;
  assign instr_valid = (count != '0);
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (pop)      fetched_q <= sat_add(fetched_q, 32'd1);
      if (br_taken) flushed_q <= sat_add(flushed_q, 32'(count) + 32'(infl_q));
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with an echo RAM (data = address).
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        nreset, br_taken, stall, instr_valid;
  logic [31:0] imem_addr, imem_q, br_target, instr_out, instr_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read RAM whose word equals its address.
  initial imem_q = '0;
  always @(posedge clk) imem_q <= imem_addr;

  instr_fetch #(.DEPTH(2), .RESET_VEC(32'h0)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .stall       (stall),
`ifdef IFETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed),
`endif
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  typedef struct {
    logic        nrst, stl, br;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc, eaddr;
    logic        pchk;
    logic [31:0] efet, eflu;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic nrst, stl, br, input logic [31:0] tgt,
                     input logic ev, input logic [31:0] epc, eaddr,
                     input logic pchk = 0, input logic [31:0] efet = 0, eflu = 0);
    vec_t v;
    v.nrst = nrst; v.stl = stl; v.br = br; v.tgt = tgt;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    v.pchk = pchk; v.efet = efet; v.eflu = eflu;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic seen;
    nreset = 0; stall = 0; br_taken = 0; br_target = '0;
    // Rows are cycles 0..31: inputs applied in that cycle, outputs expected in it.
    add(1,0,0,0,            0,32'h0,32'h0, 1,0,0);
    add(1,0,0,0,            0,32'h0,32'h4);
    add(1,0,0,0,            1,32'h0,32'h8);
    for (int i = 0; i < 10; i++) add(1,1,0,0, 1,32'h4,32'hC);
    add(1,0,0,0,            1,32'h4,32'hC);
    add(1,0,0,0,            1,32'h8,32'h10);
    add(1,0,0,0,            1,32'hC,32'h14);
    add(1,0,1,32'h103,      1,32'h10,32'h18);
    add(1,0,0,0,            0,32'h0,32'h100);
    add(1,0,0,0,            0,32'h0,32'h104);
    add(1,0,0,0,            1,32'h100,32'h108);
    add(1,1,1,32'hFFFF_FFF8,1,32'h104,32'h10C);
    add(1,0,0,0,            0,32'h0,32'hFFFF_FFF8);
    add(1,0,0,0,            0,32'h0,32'hFFFF_FFFC);
    add(1,0,0,0,            1,32'hFFFF_FFF8,32'h0);
    add(1,0,0,0,            1,32'hFFFF_FFFC,32'h4);
    add(1,1,0,0,            1,32'h0,32'h8);
    add(1,0,0,0,            1,32'h0,32'h8);
    add(1,1,0,0,            1,32'h4,32'hC);
    add(0,0,1,32'h200,      1,32'h4,32'hC, 1,8,4);
    add(1,0,0,0,            0,32'h0,32'h0, 1,0,0);
    add(1,0,0,0,            0,32'h0,32'h4);
    add(1,0,0,0,            1,32'h0,32'h8);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      chk($sformatf("valid[%0d]", i), {31'b0, instr_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("addr[%0d]", i), imem_addr, vecs[i].eaddr);
      chk($sformatf("pc[%0d]", i), instr_pc, vecs[i].epc);
      chk($sformatf("out[%0d]", i), instr_out, vecs[i].epc);
`ifdef IFETCH_PERF_EN
      if (vecs[i].pchk) begin
        chk($sformatf("fetched[%0d]", i), perf_fetched, vecs[i].efet);
        chk($sformatf("flushed[%0d]", i), perf_flushed, vecs[i].eflu);
      end
`endif
      nreset = vecs[i].nrst; stall = vecs[i].stl;
      br_taken = vecs[i].br; br_target = vecs[i].tgt;
    end

    // Redirect with a misaligned target; first valid word must arrive 3 cycles later.
    @(posedge clk); #1;
    stall = 0; br_taken = 1; br_target = 32'h43;
    @(posedge clk); #1;
    br_taken = 0; br_target = '0;
    n = 1; seen = 0;
    while (n < 10 && !seen) begin
      if (instr_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("redir_seen", {31'b0, seen}, 32'd1);
    chk("redir_latency", n, 32'd3);
    chk("redir_pc", instr_pc, 32'h40);

    // Stalled head must stay put while the FIFO fills behind it.
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_pc[%0d]", i), instr_pc, 32'h40);
      chk($sformatf("hold_out[%0d]", i), instr_out, 32'h40);
    end
    chk("hold_addr", imem_addr, 32'h48);
    stall = 0;
    @(posedge clk); #1;
    chk("release_pc", instr_pc, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
